// File: rtl/unit_clause_eliminator_if.sv
// Bus bundle for the unit-clause eliminator: load/delete enables in,
// clause register and priority-encoder status out.
interface unit_clause_eliminator_if #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
);
  logic          w_en;
  logic [W-1:0]  wd;
  logic          rw_en;
  logic [W-1:0]  unit_clause;
  logic [IW-1:0] pe_out;
  logic          pe_valid;
  logic          empty;

  modport master (
    output w_en, wd, rw_en,
    input  unit_clause, pe_out, pe_valid, empty
  );

  modport slave (
    input  w_en, wd, rw_en,
    output unit_clause, pe_out, pe_valid, empty
  );
endinterface

// File: rtl/unit_clause_eliminator.sv
// Unit-clause register with MSB-priority selection; each delete clears the
// highest set variable, giving one elimination per cycle.
module unit_clause_eliminator #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input logic                     clk,
  input logic                     rst,
  unit_clause_eliminator_if.slave bus
);

  logic [W-1:0]  r_clause;
  logic [IW-1:0] w_pe;
  logic          w_valid;
  logic [W-1:0]  w_clr_mask;

  // Ascending scan so the last hit, i.e. the highest set bit, wins.
  always_comb begin
    w_pe = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (r_clause[i]) begin
        w_pe = IW'(i);
      end
    end
  end

  assign w_valid    = |r_clause;
  assign w_clr_mask = w_valid ? (W'(1) << w_pe) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clause <= '0;
    end else if (bus.w_en) begin
      r_clause <= bus.wd;
    end else if (bus.rw_en) begin
      r_clause <= r_clause & ~w_clr_mask;
    end
  end

  assign bus.unit_clause = r_clause;
  assign bus.pe_out      = w_pe;
  assign bus.pe_valid    = w_valid;
  assign bus.empty       = ~w_valid;

endmodule

// File: tb/tb_unit_clause_eliminator.sv
// Scoreboard bench for unit_clause_eliminator: directed vectors then
// randomized traffic checked against a behavioural reference.
module tb_unit_clause_eliminator;
  localparam int W  = 8;
  localparam int IW = $clog2(W);

  typedef struct {
    string        tag;
    logic [W-1:0] uc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  logic [W-1:0] m_uc = '0;

  unit_clause_eliminator_if #(.W(W), .IW(IW)) bus ();

  unit_clause_eliminator #(.W(W), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int ref_pe(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [W-1:0] ref_next(input logic r, input logic we,
                                            input logic [W-1:0] d, input logic de,
                                            input logic [W-1:0] cur);
    logic [W-1:0] n;
    n = cur;
    if (r) n = '0;
    else if (we) n = d;
    else if (de && cur != '0) n[ref_pe(cur)] = 1'b0;
    return n;
  endfunction

  // Drive one cycle; exp_uc is the required register value after the edge.
  task automatic step(input string tag, input logic r, input logic we,
                      input logic [W-1:0] d, input logic de, input logic [W-1:0] exp_uc);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r; bus.w_en = we; bus.wd = d; bus.rw_en = de;
    m_uc = ref_next(r, we, d, de, m_uc);
    e.tag = tag; e.uc = exp_uc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      got = sb_q.pop_front();
      check({got.tag, "_uc"},    64'(bus.unit_clause), 64'(got.uc));
      check({got.tag, "_pe"},    64'(bus.pe_out),      64'(ref_pe(got.uc)));
      check({got.tag, "_valid"}, 64'(bus.pe_valid),    64'(got.uc != '0));
      check({got.tag, "_empty"}, 64'(bus.empty),       64'(got.uc == '0));
    end
  endtask

  initial begin
    rst = 1'b0; bus.w_en = 1'b0; bus.wd = '0; bus.rw_en = 1'b0;

    step("reset", 1'b1, 1'b0, 8'h00, 1'b0, 8'b00000000);
    step("load",  1'b0, 1'b1, 8'b10111011, 1'b0, 8'b10111011);
    check("load_pe7", 64'(bus.pe_out), 64'd7);
    step("del1", 1'b0, 1'b0, 8'h00, 1'b1, 8'b00111011);
    check("del1_pe5", 64'(bus.pe_out), 64'd5);
    step("del2", 1'b0, 1'b0, 8'h00, 1'b1, 8'b00011011);
    step("del3", 1'b0, 1'b0, 8'h00, 1'b1, 8'b00001011);
    step("del4", 1'b0, 1'b0, 8'h00, 1'b1, 8'b00000011);
    check("del4_pe1", 64'(bus.pe_out), 64'd1);
    step("del5", 1'b0, 1'b0, 8'h00, 1'b1, 8'b00000001);
    step("del6", 1'b0, 1'b0, 8'h00, 1'b1, 8'b00000000);
    for (int i = 0; i < 3; i++)
      step("empty_del", 1'b0, 1'b0, 8'h00, 1'b1, 8'b00000000);
    step("wr_prio", 1'b0, 1'b1, 8'b01000010, 1'b1, 8'b01000010);
    step("wr_prio_del", 1'b0, 1'b0, 8'h00, 1'b1, 8'b00000010);
    check("wr_prio_pe1", 64'(bus.pe_out), 64'd1);
    // Mid-sequence reset with load requested too
    step("reload", 1'b0, 1'b1, 8'hF0, 1'b0, 8'hF0);
    step("middel", 1'b0, 1'b0, 8'h00, 1'b1, 8'h70);
    step("rst_prio", 1'b1, 1'b1, 8'b11111111, 1'b1, 8'b00000000);

    for (int i = 0; i < 60; i++) begin
      logic r, we, de;
      logic [W-1:0] d;
      logic [W-1:0] nxt;
      r  = ($urandom_range(0, 15) == 0);
      we = ($urandom_range(0, 3) == 0);
      de = ($urandom_range(0, 3) != 0);
      d  = W'($urandom);
      nxt = ref_next(r, we, d, de, m_uc);
      step("rand", r, we, d, de, nxt);
    end

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/unit_clause_eliminator.md
UNIT_CLAUSE_ELIMINATOR -- requirements
Module: unit_clause_eliminator

Interface
REQ-001 The block SHALL have parameter W, default 8: the width of the unit-clause vector, one bit per variable; legal range is 2 to 64.
REQ-002 The block SHALL have parameter IW, default $clog2(W) = 3: the width of the variable index.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port w_en, input, 1 bit: load wd into the clause register.
REQ-006 The block SHALL have port wd, input, W bits: write data, one bit per unit-clause variable.
REQ-007 The block SHALL have port rw_en, input, 1 bit: delete enable; clears the currently selected variable.
REQ-008 The block SHALL have port unit_clause, output, W bits: the current clause register contents.
REQ-009 The block SHALL have port pe_out, output, IW bits: the index of the selected variable (priority-encoder result).
REQ-010 The block SHALL have port pe_valid, output, 1 bit: high when unit_clause has at least one bit set.
REQ-011 The block SHALL have port empty, output, 1 bit: high when unit_clause is all zeros.

Function
REQ-012 The block SHALL hold unit_clause in a W-bit register; this is the only sequential state.
REQ-013 The block SHALL compute pe_out combinationally from unit_clause: the index of the highest set bit (MSB priority).
REQ-014 When unit_clause is zero, the block SHALL drive pe_out = 0 and pe_valid = 0.
REQ-015 The block SHALL drive pe_valid = |unit_clause and empty = ~pe_valid, both combinationally.
REQ-016 On each rising edge, register updates SHALL follow this priority: rst, then w_en, then rw_en, then hold.
REQ-017 With rst = 1, the block SHALL set unit_clause to 0 regardless of w_en and rw_en.
REQ-018 With rst = 0 and w_en = 1, the block SHALL set unit_clause to wd; rw_en is ignored that cycle.
REQ-019 With rst = 0, w_en = 0, rw_en = 1 and pe_valid = 1, the block SHALL clear bit pe_out of unit_clause; all other bits are unchanged.
REQ-020 With rw_en = 1 on an empty register, unit_clause SHALL remain 0 and no other effect SHALL occur.
REQ-021 Latency SHALL be one cycle: a write or delete is visible on unit_clause and pe_out after the next rising edge; pe_out tracks unit_clause combinationally with zero added latency.
REQ-022 Holding rw_en high SHALL delete exactly one variable per cycle, highest index first, until the register is empty.
REQ-023 W that is not a power of two SHALL be supported; pe_out never exceeds W-1.
REQ-024 The outputs SHALL be free of X after the first reset edge; there is no handshake beyond the level-sensitive enables.

Reset
REQ-025 Reset SHALL be synchronous: it takes effect only at a rising clk edge while rst = 1.
REQ-026 After reset: unit_clause = 0, pe_out = 0, pe_valid = 0, empty = 1.
REQ-027 Reset asserted in the middle of a deletion sequence SHALL abort the sequence and clear the register at that edge.

Verification
REQ-028 Reset check: rst = 1 for one edge -> unit_clause = 00000000, pe_out = 0, pe_valid = 0, empty = 1.
REQ-029 Load check: w_en = 1, wd = 10111011 for one edge -> unit_clause = 10111011, pe_out = 7, pe_valid = 1.
REQ-030 Deletion sweep: rw_en = 1 for 6 edges after the load -> unit_clause steps through:
- 00111011 (pe_out = 5)
- 00011011 (pe_out = 4)
- 00001011 (pe_out = 3)
- 00000011 (pe_out = 1)
- 00000001 (pe_out = 0)
- 00000000 (pe_valid = 0, empty = 1)
REQ-031 Empty-delete check: rw_en = 1 on an empty register for 3 edges -> unit_clause stays 00000000.
REQ-032 Write-priority check: w_en = 1, rw_en = 1, wd = 01000010 -> unit_clause = 01000010 with no bit cleared; one further rw_en edge -> 00000010, pe_out = 1.
REQ-033 Reset-priority check: rst = 1, w_en = 1, wd = 11111111 -> unit_clause = 00000000.
